// File: rtl/demux32_1_2_buf_pkg.sv
// demux32_1_2_buf_pkg
// Shared constants for the 1:2 word router and the 2:1 datapath selector
// users: data/counter widths and the select-bit encoding.
//   W      : data word width in bits
//   CNT_W  : width of each per-output delivered-word counter
//   SEL_A  : select value steering a word to output A
//   SEL_B  : select value steering a word to output B
package demux32_1_2_buf_pkg;

  localparam int W     = 32;
  localparam int CNT_W = 16;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // A one-entry slot can take a new word when it is empty, or when its
  // current word leaves on the same edge.
  function automatic logic slot_can_load(input logic valid, input logic ready);
    return !valid || ready;
  endfunction

endpackage

// File: rtl/demux32_1_2_buf_out_slot.sv
// demux32_1_2_buf_out_slot
// One-entry holding register with a valid/ready output side, a load strobe
// on the input side and a counter of delivered words.
// Ports:
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   load       : write load_data into the slot this edge (caller only
//                asserts it when free=1)
//   load_data  : word to store
//   free       : slot can take a word this cycle (empty or draining)
//   valid      : slot holds a word
//   ready      : consumer takes the held word this cycle
//   data       : held word (keeps last value after draining)
//   count      : words delivered (valid & ready edges), wraps silently
//
// Handshake: a word transfers on every rising edge where valid=1 and
// ready=1; while valid=1 and ready=0 both valid and data hold steady.
module demux32_1_2_buf_out_slot
  import demux32_1_2_buf_pkg::*;
#(
  parameter int DW = demux32_1_2_buf_pkg::W,
  parameter int CW = demux32_1_2_buf_pkg::CNT_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  output logic          free,
  output logic          valid,
  input  logic          ready,
  output logic [DW-1:0] data,
  output logic [CW-1:0] count
);

  logic deliver;

  assign deliver = valid & ready;
  assign free    = slot_can_load(valid, ready);

  // A load on the same edge as a delivery replaces the word and keeps the
  // slot full, which gives one word per cycle of throughput.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (deliver) begin
      valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (deliver) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/demux32_1_2_buf.sv
// demux32_1_2_buf
// Registered 1-to-2 router: one valid/ready input stream is steered by a
// per-word select bit into one of two one-entry output slots (A or B).
// Ports:
//   clk, rst            : rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   : input handshake; in_ready is combinational from
//                         in_sel and the selected slot, never from in_valid
//   in_data, in_sel     : word and destination (SEL_A / SEL_B)
//   a_valid/a_ready/a_data, b_valid/b_ready/b_data : output handshakes
//   a_count, b_count    : delivered-word counters per output
//
// Handshake: every stream transfers on a rising edge where valid=1 and
// ready=1. The producer keeps in_sel/in_data stable while in_valid=1 and
// in_ready=0. A stalled output never blocks words steered to the other one,
// so words to different outputs may leave out of input order.
module demux32_1_2_buf
  import demux32_1_2_buf_pkg::*;
#(
  parameter int W     = demux32_1_2_buf_pkg::W,
  parameter int CNT_W = demux32_1_2_buf_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_sel,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [W-1:0]     a_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [W-1:0]     b_data,
  output logic [CNT_W-1:0] a_count,
  output logic [CNT_W-1:0] b_count
);

  logic a_free;
  logic b_free;
  logic accept;
  logic load_a;
  logic load_b;

  // Readiness only looks at the selected slot, so a full, stalled slot on
  // the other side has no influence.
  assign in_ready = (in_sel == SEL_B) ? b_free : a_free;
  assign accept   = in_valid & in_ready;
  assign load_a   = accept & (in_sel == SEL_A);
  assign load_b   = accept & (in_sel == SEL_B);

  demux32_1_2_buf_out_slot #(
    .DW (W),
    .CW (CNT_W)
  ) u_slot_a (
    .clk       (clk),
    .rst       (rst),
    .load      (load_a),
    .load_data (in_data),
    .free      (a_free),
    .valid     (a_valid),
    .ready     (a_ready),
    .data      (a_data),
    .count     (a_count)
  );

  demux32_1_2_buf_out_slot #(
    .DW (W),
    .CW (CNT_W)
  ) u_slot_b (
    .clk       (clk),
    .rst       (rst),
    .load      (load_b),
    .load_data (in_data),
    .free      (b_free),
    .valid     (b_valid),
    .ready     (b_ready),
    .data      (b_data),
    .count     (b_count)
  );

endmodule

// File: tb/tb_demux32_1_2_buf.sv
module tb_demux32_1_2_buf;
  import demux32_1_2_buf_pkg::*;

  localparam int DW  = 32;
  localparam int CW  = 16;
  localparam int CW4 = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // main DUT (default widths)
  logic          in_valid, in_ready, in_sel;
  logic [DW-1:0] in_data;
  logic          a_valid, a_ready, b_valid, b_ready;
  logic [DW-1:0] a_data, b_data;
  logic [CW-1:0] a_count, b_count;

  // narrow-counter DUT for wrap checking
  logic           in_valid4, in_ready4, in_sel4;
  logic [DW-1:0]  in_data4;
  logic           a_valid4, a_ready4, b_valid4, b_ready4;
  logic [DW-1:0]  a_data4, b_data4;
  logic [CW4-1:0] a_count4, b_count4;

  demux32_1_2_buf #(.W(DW), .CNT_W(CW)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
    .a_count(a_count), .b_count(b_count)
  );

  demux32_1_2_buf #(.W(DW), .CNT_W(CW4)) u_dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4), .in_sel(in_sel4),
    .a_valid(a_valid4), .a_ready(a_ready4), .a_data(a_data4),
    .b_valid(b_valid4), .b_ready(b_ready4), .b_data(b_data4),
    .a_count(a_count4), .b_count(b_count4)
  );

  // ---------------- scoreboard state ----------------
  int n_vec  = 0;
  int n_miss = 0;

  logic [DW-1:0] exp_a_q[$];
  logic [DW-1:0] exp_b_q[$];

  // Reference model: which outputs currently hold an undelivered word.
  bit model_a_full = 1'b0;
  bit model_b_full = 1'b0;

  // Monitor-owned delivered-word tallies.
  logic [CW-1:0] mon_a_cnt = '0;
  logic [CW-1:0] mon_b_cnt = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  // Pops the expected word whenever an output transfer is presented.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      mon_a_cnt = '0;
      mon_b_cnt = '0;
    end else if (rst === 1'b0) begin
      check("a_count", 64'(a_count), 64'(mon_a_cnt));
      check("b_count", 64'(b_count), 64'(mon_b_cnt));
      if (a_valid && a_ready) begin
        if (exp_a_q.size() == 0) check("a_unexpected_word", 64'(a_data), 64'hdead_0000);
        else check("a_data", 64'(a_data), 64'(exp_a_q.pop_front()));
        mon_a_cnt = mon_a_cnt + 1'b1;
      end
      if (b_valid && b_ready) begin
        if (exp_b_q.size() == 0) check("b_unexpected_word", 64'(b_data), 64'hdead_0000);
        else check("b_data", 64'(b_data), 64'(exp_b_q.pop_front()));
        mon_b_cnt = mon_b_cnt + 1'b1;
      end
    end
  end

  // ---------------- driver ----------------
  // Called at posedge+1: applies inputs, at the negedge checks handshake
  // against the model and records accepted words, returns at next posedge+1.
  task automatic step(input bit v, input logic s, input logic [DW-1:0] d,
                      input bit ar, input bit br, output bit acc);
    bit exp_rdy;
    in_valid = v; in_sel = s; in_data = d; a_ready = ar; b_ready = br;
    @(negedge clk);
    exp_rdy = (s == SEL_B) ? (!model_b_full || br) : (!model_a_full || ar);
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    check("a_valid", 64'(a_valid), 64'(model_a_full));
    check("b_valid", 64'(b_valid), 64'(model_b_full));
    acc = v && exp_rdy;
    if (acc && s == SEL_A) exp_a_q.push_back(d);
    if (acc && s == SEL_B) exp_b_q.push_back(d);
    model_a_full = (acc && s == SEL_A) || (model_a_full && !ar);
    model_b_full = (acc && s == SEL_B) || (model_b_full && !br);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    exp_a_q.delete();
    exp_b_q.delete();
    model_a_full = 1'b0;
    model_b_full = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a_valid"}, 64'(a_valid), 64'd0);
    check({tag, "_b_valid"}, 64'(b_valid), 64'd0);
    check({tag, "_a_data"},  64'(a_data),  64'd0);
    check({tag, "_b_data"},  64'(b_data),  64'd0);
    check({tag, "_a_count"}, 64'(a_count), 64'd0);
    check({tag, "_b_count"}, 64'(b_count), 64'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    n_miss++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    bit acc;
    bit pv;
    logic ps;
    logic [DW-1:0] pd;

    rst = 1'b1;
    in_valid = 0; in_sel = 0; in_data = '0; a_ready = 0; b_ready = 0;
    in_valid4 = 0; in_sel4 = 0; in_data4 = '0; a_ready4 = 0; b_ready4 = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    clear_model();

    // 1: single word to A
    step(1, SEL_A, 32'h1111_1111, 1, 1, acc);
    check("t1_a_data", 64'(a_data), 64'h1111_1111);
    check("t1_b_valid", 64'(b_valid), 64'd0);
    step(0, SEL_A, '0, 1, 1, acc);
    check("t1_a_count", 64'(a_count), 64'd1);
    check("t1_b_count", 64'(b_count), 64'd0);

    // 2: A stalled, second word waits, then drain+fill on one edge
    step(1, SEL_A, 32'hAAAA_0001, 0, 1, acc);
    step(1, SEL_A, 32'hAAAA_0002, 0, 1, acc);
    check("t2_stall_accept", 64'(acc), 64'd0);
    check("t2_a_data_hold", 64'(a_data), 64'hAAAA_0001);
    step(1, SEL_A, 32'hAAAA_0002, 1, 1, acc);
    check("t2_a_valid", 64'(a_valid), 64'd1);
    check("t2_a_data_new", 64'(a_data), 64'hAAAA_0002);

    // 3: A still stalled, B unaffected
    step(1, SEL_B, 32'hBBBB_0001, 0, 1, acc);
    check("t3_b_data", 64'(b_data), 64'hBBBB_0001);
    step(0, SEL_A, '0, 0, 1, acc);
    check("t3_b_count", 64'(b_count), 64'd1);
    check("t3_a_count", 64'(a_count), 64'd2);
    step(0, SEL_A, '0, 1, 1, acc);
    step(0, SEL_A, '0, 1, 1, acc);

    // 4: back-to-back alternating
    for (int i = 0; i < 8; i++) begin
      step(1, logic'(i % 2), 32'hC0DE_0000 + 32'(i), 1, 1, acc);
      check("t4_accept", 64'(acc), 64'd1);
    end
    step(0, SEL_A, '0, 1, 1, acc);
    step(0, SEL_A, '0, 1, 1, acc);
    check("t4_a_count", 64'(a_count), 64'd7);
    check("t4_b_count", 64'(b_count), 64'd5);

    // random traffic with a protocol-correct producer
    pv = 0; ps = 0; pd = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pv && $urandom_range(0, 3) != 0) begin
        pv = 1;
        ps = logic'($urandom_range(0, 1));
        pd = $urandom;
      end else if (!pv) begin
        ps = logic'($urandom_range(0, 1));
        pd = $urandom;
      end
      step(pv, ps, pd, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, acc);
      if (acc) pv = 0;
    end
    repeat (3) step(0, SEL_A, '0, 1, 1, acc);
    check("drain_a_q_empty", 64'(exp_a_q.size()), 64'd0);
    check("drain_b_q_empty", 64'(exp_b_q.size()), 64'd0);

    // 6: asynchronous reset with both slots full
    step(1, SEL_A, 32'h5A5A_0001, 0, 0, acc);
    step(1, SEL_B, 32'h5A5A_0002, 0, 0, acc);
    check("t6_a_full", 64'(a_valid), 64'd1);
    check("t6_b_full", 64'(b_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    clear_model();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(0, SEL_A, '0, 0, 0, acc);
    step(0, SEL_B, '0, 0, 0, acc);
    step(1, SEL_B, 32'h0000_BEEF, 1, 1, acc);
    step(0, SEL_A, '0, 1, 1, acc);
    step(0, SEL_A, '0, 1, 1, acc);

    // 5: counter wrap on the narrow-counter instance (17 deliveries on B)
    in_valid4 = 1; in_sel4 = SEL_B; a_ready4 = 1; b_ready4 = 1;
    for (int j = 1; j <= 18; j++) begin
      in_data4 = 32'(j);
      @(posedge clk);
      #1;
      if (j == 17) in_valid4 = 0;
      check("wrap_b_count4", 64'(b_count4), 64'((j - 1) % 16));
    end
    check("wrap_a_count4", 64'(a_count4), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
